// File: rtl/float_to_int_converter.sv
// Converts an IEEE-754 binary32 operand to a 32-bit two's-complement integer, truncating toward zero.
// Latency: valid pulses k+1 cycles after the accepting edge (k = |e-23| for normal inputs, 0 for special cases).
// Backpressure: none downstream; load is only accepted in IDLE and is silently dropped while busy.
module float_to_int_converter (
  input  logic        clk,
  input  logic        rst,
  input  logic        load,
  input  logic [31:0] inA,
  output logic [31:0] out,
  output logic        valid,
  output logic        busy,
  output logic        overflow,
  output logic        invalid,
  output logic        inexact
);

  typedef enum logic [1:0] {
    IDLE   = 2'd0,
    SHIFT  = 2'd1,
    FINISH = 2'd2
  } state_t;

  // Bias 127 plus 23 fraction bits: a biased exponent of 150 means the
  // significand already sits at the integer binary point.
  localparam logic [7:0]  EXP_POINT = 8'd150;
  localparam logic [7:0]  EXP_BIAS  = 8'd127;
  // Smallest biased exponent whose magnitude is at least 2^31.
  localparam logic [7:0]  EXP_SAT   = 8'd158;
  localparam logic [31:0] INT_MAX   = 32'h7FFF_FFFF;
  localparam logic [31:0] INT_MIN   = 32'h8000_0000;
  // -2^31 is the one value at or beyond 2^31 that is representable.
  localparam logic [31:0] FLT_MIN_INT = 32'hCF00_0000;

  state_t      state;
  logic [31:0] acc;
  logic [4:0]  count;
  logic        sticky;
  logic        sign;
  logic        left;
  logic        sat_pend;
  logic        nan_pend;

  logic [7:0]  exp_f;
  logic [22:0] frac_f;
  logic        sgn_f;

  assign sgn_f  = inA[31];
  assign exp_f  = inA[30:23];
  assign frac_f = inA[22:0];

  // Decoded view of inA, used only on the accepting edge.
  logic        dec_nan;
  logic        dec_sat;
  logic        dec_inx;
  logic        dec_left;
  logic [4:0]  dec_k;
  logic [31:0] dec_acc;

  // Classify the operand and derive the initial accumulator, shift count and direction.
  always_comb begin
    dec_nan  = 1'b0;
    dec_sat  = 1'b0;
    dec_inx  = 1'b0;
    dec_left = 1'b0;
    dec_k    = 5'd0;
    dec_acc  = {8'd0, 1'b1, frac_f};
    if (exp_f == 8'hFF) begin
      // Infinity saturates, NaN reports invalid with a zero result.
      dec_acc = 32'd0;
      if (frac_f != 23'd0) begin
        dec_nan = 1'b1;
      end else begin
        dec_sat = 1'b1;
      end
    end else if (exp_f == 8'd0) begin
      // Zero and denormals truncate to 0; any fraction bit is lost.
      dec_acc = 32'd0;
      dec_inx = (frac_f != 23'd0);
    end else if (exp_f < EXP_BIAS) begin
      // 0 < |x| < 1: nonzero value always truncates to 0.
      dec_acc = 32'd0;
      dec_inx = 1'b1;
    end else if (exp_f >= EXP_SAT) begin
      if (inA == FLT_MIN_INT) begin
        // Exact -2^31; negating 0x80000000 in FINISH leaves it unchanged.
        dec_acc = INT_MIN;
      end else begin
        dec_acc = 32'd0;
        dec_sat = 1'b1;
      end
    end else if (exp_f > EXP_POINT) begin
      dec_left = 1'b1;
      dec_k    = 5'(exp_f - EXP_POINT);
    end else begin
      dec_k    = 5'(EXP_POINT - exp_f);
    end
  end

  // Control FSM plus datapath: shift one bit per SHIFT cycle, resolve sign and flags in FINISH.
  always_ff @(posedge clk) begin
    if (rst) begin
      state    <= IDLE;
      acc      <= 32'd0;
      count    <= 5'd0;
      sticky   <= 1'b0;
      sign     <= 1'b0;
      left     <= 1'b0;
      sat_pend <= 1'b0;
      nan_pend <= 1'b0;
      out      <= 32'd0;
      valid    <= 1'b0;
      overflow <= 1'b0;
      invalid  <= 1'b0;
      inexact  <= 1'b0;
    end else begin
      valid <= 1'b0;
      case (state)
        IDLE: begin
          if (load) begin
            acc      <= dec_acc;
            count    <= dec_k;
            sticky   <= dec_inx;
            sign     <= sgn_f;
            left     <= dec_left;
            sat_pend <= dec_sat;
            nan_pend <= dec_nan;
            state    <= (dec_k == 5'd0) ? FINISH : SHIFT;
          end
        end
        SHIFT: begin
          if (left) begin
            acc <= acc << 1;
          end else begin
            // Bits falling off the bottom are fraction bits being truncated.
            acc    <= acc >> 1;
            sticky <= sticky | acc[0];
          end
          count <= count - 5'd1;
          if (count == 5'd1) begin
            state <= FINISH;
          end
        end
        FINISH: begin
          valid    <= 1'b1;
          overflow <= sat_pend;
          invalid  <= nan_pend;
          inexact  <= sticky;
          if (nan_pend) begin
            out <= 32'd0;
          end else if (sat_pend) begin
            out <= sign ? INT_MIN : INT_MAX;
          end else begin
            out <= sign ? (~acc + 32'd1) : acc;
          end
          state <= IDLE;
        end
        default: begin
          state <= IDLE;
        end
      endcase
    end
  end

  // Any state other than IDLE means a conversion is in flight.
  assign busy = (state != IDLE);

endmodule

// File: tb/tb_float_to_int_converter.sv
// Bench for float_to_int_converter: directed cases with fixed expectations,
// randomized operands checked against a magnitude-based reference model,
// plus dropped-load, back-to-back and mid-conversion reset scenarios.
module tb_float_to_int_converter;

  logic        clk;
  logic        rst;
  logic        load;
  logic [31:0] inA;
  logic [31:0] out;
  logic        valid;
  logic        busy;
  logic        overflow;
  logic        invalid;
  logic        inexact;

  int n_cmp = 0;
  int n_bad = 0;

  float_to_int_converter dut (
    .clk      (clk),
    .rst      (rst),
    .load     (load),
    .inA      (inA),
    .out      (out),
    .valid    (valid),
    .busy     (busy),
    .overflow (overflow),
    .invalid  (invalid),
    .inexact  (inexact)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  task automatic chk(input string tag, input logic [63:0] got, input logic [63:0] exp);
    n_cmp++;
    if (got !== exp) begin
      n_bad++;
      $display("FAIL %s: got %h expected %h", tag, got, exp);
    end
  endtask

  // Reference: value = m * 2^(e-23), truncated; result packed as {out, overflow, invalid, inexact}.
  function automatic logic [34:0] ref_conv(input logic [31:0] a);
    logic        sgn;
    int          ex;
    int          e;
    logic [63:0] m;
    logic [63:0] mag;
    logic        inx;
    logic [31:0] r;
    logic [31:0] sat_val;
    sgn     = a[31];
    ex      = int'(a[30:23]);
    sat_val = sgn ? 32'h8000_0000 : 32'h7FFF_FFFF;
    if (ex == 255) begin
      if (a[22:0] != 23'd0) return {32'd0, 3'b010};
      return {sat_val, 3'b100};
    end
    if (ex == 0) begin
      m = {41'd0, a[22:0]};
      e = -126;
    end else begin
      m = {40'd0, 1'b1, a[22:0]};
      e = ex - 127;
    end
    inx = 1'b0;
    if (e >= 23) begin
      mag = (e - 23 > 40) ? 64'hFFFF_FFFF_FFFF_FFFF : (m << (e - 23));
    end else if (23 - e >= 64) begin
      mag = 64'd0;
      inx = (m != 64'd0);
    end else begin
      mag = m >> (23 - e);
      inx = ((mag << (23 - e)) != m);
    end
    if (mag > 64'h8000_0000 || (mag == 64'h8000_0000 && !sgn)) return {sat_val, 3'b100};
    r = mag[31:0];
    if (sgn) r = -r;
    return {r, 2'b00, inx};
  endfunction

  // Expected cycles from accept edge to valid: one per shifted bit, plus one.
  function automatic int ref_lat(input logic [31:0] a);
    int ex;
    ex = int'(a[30:23]);
    if (ex == 255 || ex < 127 || ex >= 158) return 1;
    return ((ex > 150) ? (ex - 150) : (150 - ex)) + 1;
  endfunction

  // Called at the first falling edge after the accepting edge (n = start there).
  task automatic wait_valid(input int start, output int n);
    n = start;
    while (valid !== 1'b1 && n < 40) begin
      @(negedge clk);
      n++;
    end
  endtask

  task automatic run_one(input string tag, input logic [31:0] a,
                         input logic [34:0] exp_res, input int exp_lat);
    int          n;
    logic [31:0] held;
    @(negedge clk);
    load = 1'b1;
    inA  = a;
    @(negedge clk);
    load = 1'b0;
    inA  = $urandom;
    chk({tag, "/busy"}, 64'(busy), 64'd1);
    wait_valid(0, n);
    chk({tag, "/lat"}, 64'(n), 64'(exp_lat));
    chk({tag, "/res"}, 64'({out, overflow, invalid, inexact}), 64'(exp_res));
    chk({tag, "/busy_at_valid"}, 64'(busy), 64'd0);
    held = out;
    @(negedge clk);
    chk({tag, "/pulse"}, 64'(valid), 64'd0);
    chk({tag, "/hold"}, 64'(out), 64'(held));
  endtask

  logic [31:0] dir_a   [14];
  logic [34:0] dir_res [14];
  int          dir_lat [14];

  initial begin
    int          n;
    int          seen;
    logic [31:0] a;

    dir_a[0]  = 32'h3FC0_0000; dir_res[0]  = {32'h0000_0001, 3'b001}; dir_lat[0]  = 24;
    dir_a[1]  = 32'hC040_0000; dir_res[1]  = {32'hFFFF_FFFD, 3'b000}; dir_lat[1]  = 23;
    dir_a[2]  = 32'h4146_6666; dir_res[2]  = {32'h0000_000C, 3'b001}; dir_lat[2]  = 21;
    dir_a[3]  = 32'h4E80_0000; dir_res[3]  = {32'h4000_0000, 3'b000}; dir_lat[3]  = 8;
    dir_a[4]  = 32'hCF00_0000; dir_res[4]  = {32'h8000_0000, 3'b000}; dir_lat[4]  = 1;
    dir_a[5]  = 32'h4F00_0000; dir_res[5]  = {32'h7FFF_FFFF, 3'b100}; dir_lat[5]  = 1;
    dir_a[6]  = 32'hFFFF_FFFF; dir_res[6]  = {32'h0000_0000, 3'b010}; dir_lat[6]  = 1;
    dir_a[7]  = 32'hFF80_0000; dir_res[7]  = {32'h8000_0000, 3'b100}; dir_lat[7]  = 1;
    dir_a[8]  = 32'h0000_0001; dir_res[8]  = {32'h0000_0000, 3'b001}; dir_lat[8]  = 1;
    dir_a[9]  = 32'h8000_0000; dir_res[9]  = {32'h0000_0000, 3'b000}; dir_lat[9]  = 1;
    dir_a[10] = 32'h3F00_0000; dir_res[10] = {32'h0000_0000, 3'b001}; dir_lat[10] = 1;
    dir_a[11] = 32'h4B00_0000; dir_res[11] = {32'h0080_0000, 3'b000}; dir_lat[11] = 1;
    dir_a[12] = 32'hCF00_0001; dir_res[12] = {32'h8000_0000, 3'b100}; dir_lat[12] = 1;
    dir_a[13] = 32'h4EFF_FFFF; dir_res[13] = {32'h7FFF_FF80, 3'b000}; dir_lat[13] = 8;

    rst  = 1'b1;
    load = 1'b0;
    inA  = 32'd0;
    repeat (3) @(negedge clk);
    chk("reset", 64'({out, valid, busy, overflow, invalid, inexact}), 64'd0);
    rst = 1'b0;

    for (int i = 0; i < 14; i++) begin
      run_one($sformatf("dir%0d", i), dir_a[i], dir_res[i], dir_lat[i]);
    end

    for (int i = 0; i < 200; i++) begin
      a = $urandom;
      if (i % 2 == 1) a[30:23] = 8'($urandom_range(170, 100));
      run_one($sformatf("rand%0d_%h", i, a), a, ref_conv(a), ref_lat(a));
    end

    // A load issued mid-conversion is dropped; a load in the cycle of valid is taken.
    @(negedge clk);
    load = 1'b1;
    inA  = 32'h3FC0_0000;
    @(negedge clk);
    load = 1'b0;
    repeat (5) @(negedge clk);
    load = 1'b1;
    inA  = 32'h4040_0000;
    @(negedge clk);
    load = 1'b0;
    wait_valid(6, n);
    chk("drop/lat", 64'(n), 64'd24);
    chk("drop/res", 64'({out, overflow, invalid, inexact}), 64'({32'h0000_0001, 3'b001}));
    load = 1'b1;
    inA  = 32'hC040_0000;
    @(negedge clk);
    load = 1'b0;
    chk("b2b/busy", 64'(busy), 64'd1);
    wait_valid(0, n);
    chk("b2b/lat", 64'(n), 64'd23);
    chk("b2b/res", 64'({out, overflow, invalid, inexact}), 64'({32'hFFFF_FFFD, 3'b000}));

    // Reset mid-conversion, coinciding with a load, aborts without a valid pulse.
    @(negedge clk);
    load = 1'b1;
    inA  = 32'h3FC0_0000;
    @(negedge clk);
    load = 1'b0;
    repeat (10) @(negedge clk);
    rst  = 1'b1;
    load = 1'b1;
    inA  = 32'h4E80_0000;
    @(negedge clk);
    rst  = 1'b0;
    load = 1'b0;
    chk("rst_mid/outs", 64'({out, valid, busy, overflow, invalid, inexact}), 64'd0);
    seen = 0;
    repeat (30) begin
      @(negedge clk);
      if (valid === 1'b1) seen = 1;
    end
    chk("rst_mid/no_valid", 64'(seen), 64'd0);
    run_one("after_rst", 32'h3FC0_0000, {32'h0000_0001, 3'b001}, 24);

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
    $finish;
  end

  initial begin
    #2_000_000;
    $display("FAIL watchdog: simulation did not complete");
    $fatal(1, "timeout");
  end

endmodule

// File: doc/float_to_int_converter.md
FLOAT_TO_INT_CONVERTER -- requirements
Module: float_to_int_converter

Interface
REQ-001: Parameters: none; format fixed to IEEE-754 binary32 in, two's-complement 32-bit out.
REQ-002: clk  input  1  single clock; all state updates on rising edge.
REQ-003: rst  input  1  reset, synchronous, active-high.
REQ-004: load  input  1  request; samples inA when accepted.
REQ-005: inA  input  32  IEEE-754 binary32 operand (sign, 8-bit exponent, 23-bit fraction).
REQ-006: out  output  32  signed integer result, truncated toward zero; held until next valid.
REQ-007: valid  output  1  one-cycle pulse; out and flags are correct in that cycle.
REQ-008: busy  output  1  high in every state except IDLE; load ignored while high.
REQ-009: overflow  output  1  result saturated (|x| >= 2^31 except exactly -2^31, or infinity).
REQ-010: invalid  output  1  input was NaN.
REQ-011: inexact  output  1  nonzero fraction bits discarded by truncation.

Function
REQ-012: FSM states IDLE, SHIFT, FINISH; IDLE->SHIFT on accepted load if k>0; IDLE->FINISH on accepted load if k=0 or special case; SHIFT->FINISH when count reaches 0; FINISH->IDLE unconditionally.
REQ-013: Decode on accept: E = inA[30:23], e = E-127, significand m = {1,inA[22:0]} in a 32-bit accumulator.
REQ-014: Shift count k = |e-23|; direction left if e>23, right if e<23; one bit per SHIFT cycle.
REQ-015: Right shifts OR each discarded bit into a sticky bit; inexact = sticky at FINISH.
REQ-016: Special cases bypass SHIFT (k treated as 0): E=0 (zero/denormal) -> 0, inexact = (fraction!=0); 0<E<127 -> 0, inexact=1; E=255 fraction!=0 -> 0, invalid=1; E=255 fraction=0 -> saturate, overflow=1; 158<=E<255 -> saturate, overflow=1, except inA=0xCF000000 -> 0x80000000, no flags.
REQ-017: Saturation: positive -> 0x7FFFFFFF, negative -> 0x80000000.
REQ-018: FINISH applies sign (two's-complement negate if sign=1 and not saturated), registers out and all flags, asserts valid for exactly that one cycle.
REQ-019: Latency: valid is high in the (k+1)th cycle after the load-accept edge; k in 0..23.
REQ-020: Flags are cleared together and rewritten only at FINISH; all three are valid only while valid=1, held otherwise.
REQ-021: load while busy=1 (SHIFT or FINISH) is dropped, no side effect; load in the IDLE cycle immediately following FINISH is accepted.
REQ-022: -0.0 (0x80000000) -> out 0x00000000, no flags.

Reset
REQ-023: rst high at an edge forces IDLE; out=0, valid=0, busy=0, overflow=0, invalid=0, inexact=0; sticky and count cleared.
REQ-024: rst has priority over load at the same edge; the load is dropped.
REQ-025: rst mid-SHIFT aborts the conversion; no valid pulse is produced for it.

Verification
REQ-026: load, inA=0x3FC00000 (1.5) -> valid after 24 cycles, out=0x00000001, inexact=1, others 0.
REQ-027: inA=0xC0400000 (-3.0) -> valid after 23 cycles, out=0xFFFFFFFD, no flags; inA=0x41466666 (12.4) -> out=0x0000000C, inexact=1.
REQ-028: inA=0x4E800000 (2^30) -> valid after 8 cycles, out=0x40000000; inA=0xCF000000 -> valid after 1 cycle, out=0x80000000, no flags; inA=0x4F000000 -> out=0x7FFFFFFF, overflow=1.
REQ-029: inA=0xFFFFFFFF (NaN) -> valid after 1 cycle, out=0, invalid=1; inA=0xFF800000 -> out=0x80000000, overflow=1; inA=0x00000001 -> out=0, inexact=1.
REQ-030: second load issued 5 cycles into a 1.5 conversion -> ignored, single valid with out=1; back-to-back load in the cycle after FINISH -> accepted.
REQ-031: rst asserted 10 cycles into a 1.5 conversion, together with load -> all outputs 0 next cycle, no valid pulse, next load after rst low converts normally.
